pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Instruction-fetch PC stage of the MIPS core. Holds the program counter and issues instruction-memory requests over a req/ack handshake.
- Presents fetched instructions to IF/ID with a valid/ready handshake.
- Computes the next PC from: sequential PC+4, branch target (PC+4 base plus the already-shifted word offset produced by the shift-left-twice stage), or jump target.
- Sits directly downstream of the shift-left-twice stage on the branch path.

Parameters:
- WIDTH, 32, PC, address and instruction width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall_i  input  1  hazard stall; no new imem request is issued while high.
- branch_taken_i  input  1  one-cycle pulse, redirect to branch target.
- branch_base_i  input  WIDTH  PC+4 of the branch instruction.
- branch_offset_i  input  WIDTH  sign-extended immediate, already shifted left by 2.
- jump_i  input  1  one-cycle pulse, redirect to jump_target_i.
- jump_target_i  input  WIDTH  absolute jump address.
- imem_req_o  output  1  memory request, held until ack.
- imem_addr_o  output  WIDTH  request address, stable while req is high.
- imem_ack_i  input  1  memory response valid, with instr_i.
- instr_i  input  WIDTH  returned instruction.
- if_valid_o  output  1  if_instr_o / if_pc_plus4_o valid.
- if_instr_o  output  WIDTH  fetched instruction.
- if_pc_plus4_o  output  WIDTH  PC+4 of the fetched instruction.
- if_ready_i  input  1  IF/ID accepts when valid and ready.
- misalign_o  output  1  sticky misaligned-target flag (see Optional Feature).

Behaviour:
- Reset (async, rst_n low):
  - pc = RESET_PC; state = IDLE.
  - imem_req_o = 0; if_valid_o = 0; if_instr_o = 0; if_pc_plus4_o = 0; misalign_o = 0.
  - Pending-redirect register cleared.
- States:
  - IDLE: if !stall_i, go to REQ next cycle with imem_req_o = 1 and imem_addr_o = pc.
  - REQ: hold req and addr until imem_ack_i.
    - On ack without a squash: capture instr_i into if_instr_o and pc+4 into if_pc_plus4_o; set if_valid_o; pc <= pc+4; go to HOLD.
  - HOLD: when if_ready_i is high, the transfer completes that cycle.
    - If !stall_i, issue the next request in the same cycle (REQ) and drop if_valid_o; otherwise go to IDLE.
- Redirect target arithmetic:
  - Branch target = branch_base_i + branch_offset_i, modulo 2^WIDTH (wrap-around, no overflow flag).
  - Computed combinationally and registered into pc.
- Redirect priority: branch_taken_i beats jump_i if both arrive in the same cycle.
- Redirect in IDLE or HOLD:
  - pc <= target next cycle; if_valid_o cleared (the held instruction is squashed).
  - State goes to IDLE, or directly to REQ when !stall_i.
- Redirect in REQ:
  - The outstanding request cannot be cancelled. Store the target in the pending register and set the squash flag.
  - On ack, discard instr_i (if_valid_o stays 0), load pc from the pending register, then issue a new request.
  - A second redirect before ack overwrites the pending target (newest wins).
- Ack and redirect in the same cycle in REQ: the returning instruction is squashed and the target is used.
- stall_i affects only new request issue. An outstanding request still completes and its data is held in HOLD.
- Latency: with zero-wait memory (ack one cycle after req) and if_ready_i held high, the stage sustains one instruction every 2 cycles.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - Any redirect target with bits [1:0] != 0 sets misalign_o, which stays set until reset.
  - The target is still loaded with bits [1:0] forced to 0.
- Undefined: misalign_o is tied to 0 and the target is loaded unmodified.

Decomposition:
- Shared package mips_pkg holds:
  - Fetch state enum: IDLE, REQ, HOLD.
  - PC_STEP = 4.
  - Default RESET_PC constant.
- One natural sub-module: branch_target_adder (WIDTH-bit base + offset), reusable by the branch unit.

Test Plan:
- Reset release, zero-wait memory, if_ready_i = 1 -> imem_addr_o sequence 0x0, 0x4, 0x8; if_pc_plus4_o 0x4, 0x8, 0xC.
- Branch in HOLD with branch_base_i = 0x100, branch_offset_i = 0xFFFF_FFF0 -> next imem_addr_o = 0xF0; held instruction dropped.
- Branch during REQ at addr 0x20 (ack delayed 3 cycles), base = 0x24, offset = 0x40 -> 0x20 data discarded; next request at 0x64.
- branch_taken_i and jump_i together (branch target 0x80, jump_target_i 0x400) -> next request at 0x80.
- stall_i held 5 cycles during REQ -> ack still captured and held in HOLD; no new request until stall_i falls; rst_n pulsed mid-REQ -> all outputs 0 and pc = RESET_PC immediately.
- With PC_ALIGN_CHECK_EN, jump_target_i = 0x402 -> misalign_o = 1 (sticky); request issued at 0x400.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: fetch FSM states, PC increment and reset vector.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  localparam int unsigned PC_STEP          = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/branch_target_adder.sv
// Branch target = PC+4 base plus pre-shifted word offset, wrapping modulo 2^WIDTH.
module branch_target_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] base_i,
  input  logic [WIDTH-1:0] offset_i,
  output logic [WIDTH-1:0] target_o
);

  assign target_o = base_i + offset_i;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch PC stage: imem req/ack master, IF/ID valid/ready source, redirect handling.
// Optional PC_ALIGN_CHECK_EN: flag and word-align misaligned redirect targets.
module pc_fetch_ctrl
  import mips_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             branch_taken_i,
  input  logic [WIDTH-1:0] branch_base_i,
  input  logic [WIDTH-1:0] branch_offset_i,
  input  logic             jump_i,
  input  logic [WIDTH-1:0] jump_target_i,
  output logic             imem_req_o,
  output logic [WIDTH-1:0] imem_addr_o,
  input  logic             imem_ack_i,
  input  logic [WIDTH-1:0] instr_i,
  output logic             if_valid_o,
  output logic [WIDTH-1:0] if_instr_o,
  output logic [WIDTH-1:0] if_pc_plus4_o,
  input  logic             if_ready_i,
  output logic             misalign_o
);

  fetch_state_e     state_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pend_q;
  logic             squash_q;
  logic             req_q;
  logic             valid_q;
  logic [WIDTH-1:0] instr_q;
  logic [WIDTH-1:0] pc_plus4_q;

  logic [WIDTH-1:0] branch_target;
  logic [WIDTH-1:0] redirect_raw;
  logic [WIDTH-1:0] redirect_target;
  logic [WIDTH-1:0] pc_inc;
  logic             redirect;

  branch_target_adder #(.WIDTH(WIDTH)) u_branch_target_adder (
    .base_i   (branch_base_i),
    .offset_i (branch_offset_i),
    .target_o (branch_target)
  );

  assign redirect     = branch_taken_i | jump_i;
  assign redirect_raw = branch_taken_i ? branch_target : jump_target_i;
  assign pc_inc       = pc_q + WIDTH'(PC_STEP);

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_q;

  assign redirect_target = {redirect_raw[WIDTH-1:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      misalign_q <= 1'b0;
    else if (redirect && (redirect_raw[1:0] != 2'b00))
      misalign_q <= 1'b1;
  end

  assign misalign_o = misalign_q;
`else
  assign redirect_target = redirect_raw;
  assign misalign_o      = 1'b0;
`endif

  // NOTE: every register here updates with <= so all next-state terms read pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      pend_q     <= '0;
      squash_q   <= 1'b0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_plus4_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (redirect) pc_q <= redirect_target;
          if (!stall_i) begin
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end
        REQ: begin
          if (imem_ack_i) begin
            if (squash_q || redirect) begin
              // Wrong-path data returns: drop it and restart from the newest target.
              pc_q     <= redirect ? redirect_target : pend_q;
              squash_q <= 1'b0;
              if (stall_i) begin
                state_q <= IDLE;
                req_q   <= 1'b0;
              end
            end else begin
              instr_q    <= instr_i;
              pc_plus4_q <= pc_inc;
              valid_q    <= 1'b1;
              pc_q       <= pc_inc;
              state_q    <= HOLD;
              req_q      <= 1'b0;
            end
          end else if (redirect) begin
            pend_q   <= redirect_target;
            squash_q <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect || if_ready_i) begin
            valid_q <= 1'b0;
            if (redirect) pc_q <= redirect_target;
            state_q <= stall_i ? IDLE : REQ;
            req_q   <= !stall_i;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign if_valid_o    = valid_q;
  assign if_instr_o    = instr_q;
  assign if_pc_plus4_o = pc_plus4_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus randomized traffic vs a transaction model.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        branch_taken_i;
  logic [31:0] branch_base_i;
  logic [31:0] branch_offset_i;
  logic        jump_i;
  logic [31:0] jump_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] instr_i;
  logic        if_valid_o;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_plus4_o;
  logic        if_ready_i;
  logic        misalign_o;

  pc_fetch_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_base_i   (branch_base_i),
    .branch_offset_i (branch_offset_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_ack_i      (imem_ack_i),
    .instr_i         (instr_i),
    .if_valid_o      (if_valid_o),
    .if_instr_o      (if_instr_o),
    .if_pc_plus4_o   (if_pc_plus4_o),
    .if_ready_i      (if_ready_i),
    .misalign_o      (misalign_o)
  );

  always #5 clk = ~clk;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference: one outstanding fetch, one held instruction, one pending redirect.
  logic [31:0] m_pc;
  bit          m_busy, m_squash, m_has, m_mis;
  logic [31:0] m_pend, m_instr, m_pc4;

  task automatic model_reset();
    m_pc = RESET_PC; m_busy = 0; m_squash = 0; m_has = 0; m_mis = 0;
    m_pend = '0; m_instr = '0; m_pc4 = '0;
  endtask

  task automatic model_update();
    logic [31:0] tgt;
    bit redir;
    redir = branch_taken_i || jump_i;
    tgt   = branch_taken_i ? branch_base_i + branch_offset_i : jump_target_i;
    if (redir && ALIGN_EN) begin
      if (tgt[1:0] != 2'b00) m_mis = 1;
      tgt = tgt & ~32'd3;
    end
    if (m_busy) begin
      if (redir) begin m_pend = tgt; m_squash = 1; end
      if (imem_ack_i) begin
        m_busy = 0;
        if (m_squash) begin
          m_pc = m_pend; m_squash = 0; m_busy = !stall_i;
        end else begin
          m_has = 1; m_instr = instr_i; m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
        end
      end
    end else if (redir) begin
      m_pc = tgt; m_has = 0; m_busy = !stall_i;
    end else if (!m_has || if_ready_i) begin
      m_has = 0; m_busy = !stall_i;
    end
  endtask

  task automatic compare_all();
    check("req", 32'(imem_req_o), 32'(m_busy));
    if (m_busy) check("addr", imem_addr_o, m_pc);
    check("valid", 32'(if_valid_o), 32'(m_has));
    if (m_has) begin
      check("instr", if_instr_o, m_instr);
      check("pc_plus4", if_pc_plus4_o, m_pc4);
    end
    check("misalign", 32'(misalign_o), 32'(m_mis));
  endtask

  // Memory responder: fixed or random wait states per request.
  bit          mem_busy, mem_rand, last_ack;
  int          mem_wait, mem_delay, mem_fixed, cycle;
  logic [31:0] ack_addr_q[$];
  int          ack_cyc_q[$];
  logic [31:0] pc4_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
  endfunction

  // Called at a negedge: drive memory response, clock once, update model, compare.
  task automatic step();
    bit ack_now;
    if (imem_req_o) begin
      if (!mem_busy) begin
        mem_busy  = 1; mem_wait = 0;
        mem_delay = mem_rand ? int'($urandom_range(0, 3)) : mem_fixed;
      end
      if (mem_wait == mem_delay) begin
        imem_ack_i = 1; instr_i = mem_word(imem_addr_o);
      end else begin
        imem_ack_i = 0; mem_wait++;
      end
    end else begin
      imem_ack_i = 0;
    end
    ack_now = imem_req_o && imem_ack_i;
    if (ack_now) begin ack_addr_q.push_back(imem_addr_o); ack_cyc_q.push_back(cycle); end
    if (if_valid_o && if_ready_i) pc4_q.push_back(if_pc_plus4_o);
    @(posedge clk);
    model_update();
    if (ack_now) mem_busy = 0;
    last_ack = ack_now;
    cycle++;
    #1 compare_all();
    @(negedge clk);
    branch_taken_i = 0; jump_i = 0; imem_ack_i = 0;
  endtask

  task automatic run_until_valid(input string tag);
    for (int i = 0; i < 12 && !if_valid_o; i++) step();
    check(tag, 32'(if_valid_o), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;
    rst_n = 0; stall_i = 0; branch_taken_i = 0; jump_i = 0; if_ready_i = 1;
    branch_base_i = '0; branch_offset_i = '0; jump_target_i = '0;
    imem_ack_i = 0; instr_i = '0;
    mem_busy = 0; mem_rand = 0; mem_fixed = 0; cycle = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_req", 32'(imem_req_o), 32'd0);
    check("rst_valid", 32'(if_valid_o), 32'd0);
    check("rst_instr", if_instr_o, 32'd0);
    check("rst_pc4", if_pc_plus4_o, 32'd0);
    check("rst_misalign", 32'(misalign_o), 32'd0);
    check("rst_pc", imem_addr_o, RESET_PC);
    rst_n = 1;

    // Sequential fetch, zero-wait memory, IF/ID always ready.
    repeat (7) step();
    check("seq_n_acks", 32'(ack_addr_q.size()), 32'd3);
    check("seq_n_xfers", 32'(pc4_q.size()), 32'd3);
    if (ack_addr_q.size() >= 3 && pc4_q.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        check("seq_addr", ack_addr_q[i], 32'(4 * i));
        check("seq_pc4", pc4_q[i], 32'(4 * i + 4));
      end
      check("seq_rate", 32'(ack_cyc_q[2] - ack_cyc_q[1]), 32'd2);
    end

    // Branch while holding an instruction (negative offset).
    if_ready_i = 0;
    run_until_valid("hold_reached_1");
    branch_taken_i = 1; branch_base_i = 32'h100; branch_offset_i = 32'hFFFF_FFF0;
    step();
    check("br_hold_req", 32'(imem_req_o), 32'd1);
    check("br_hold_addr", imem_addr_o, 32'h0000_00F0);
    check("br_hold_drop", 32'(if_valid_o), 32'd0);

    // Branch during an outstanding request to 0x20 with a slow memory.
    run_until_valid("hold_reached_2");
    mem_fixed = 3;
    jump_i = 1; jump_target_i = 32'h20;
    step();
    check("jmp_addr_20", imem_addr_o, 32'h20);
    branch_taken_i = 1; branch_base_i = 32'h24; branch_offset_i = 32'h40;
    saw = 0;
    for (int i = 0; i < 10 && !saw; i++) begin step(); saw = last_ack; end
    check("br_req_ack_seen", 32'(saw), 32'd1);
    check("br_req_discard", 32'(if_valid_o), 32'd0);
    check("br_req_reissue", 32'(imem_req_o), 32'd1);
    check("br_req_addr", imem_addr_o, 32'h64);
    mem_fixed = 0;
    run_until_valid("hold_reached_3");
    check("br_req_pc4", if_pc_plus4_o, 32'h68);

    // Branch and jump together: branch wins.
    mem_fixed = 2;
    branch_taken_i = 1; branch_base_i = 32'h40; branch_offset_i = 32'h40;
    jump_i = 1; jump_target_i = 32'h400;
    step();
    check("prio_addr", imem_addr_o, 32'h80);

    // Stall during an outstanding request: data still captured and held.
    stall_i = 1;
    repeat (5) step();
    check("stall_valid", 32'(if_valid_o), 32'd1);
    check("stall_no_req", 32'(imem_req_o), 32'd0);
    check("stall_pc4", if_pc_plus4_o, 32'h84);
    stall_i = 0; if_ready_i = 1;
    step();
    check("unstall_req", 32'(imem_req_o), 32'd1);
    check("unstall_addr", imem_addr_o, 32'h84);

    // Asynchronous reset in the middle of a request.
    mem_fixed = 3; if_ready_i = 0;
    step();
    #2 rst_n = 0;
    #1;
    check("mid_rst_req", 32'(imem_req_o), 32'd0);
    check("mid_rst_valid", 32'(if_valid_o), 32'd0);
    check("mid_rst_instr", if_instr_o, 32'd0);
    check("mid_rst_pc4", if_pc_plus4_o, 32'd0);
    check("mid_rst_pc", imem_addr_o, RESET_PC);
    model_reset();
    mem_busy = 0; imem_ack_i = 0;
    @(negedge clk);
    rst_n = 1;

    // Misaligned jump target.
    mem_fixed = 0;
    run_until_valid("hold_reached_4");
    jump_i = 1; jump_target_i = 32'h402;
    step();
    check("mis_flag", 32'(misalign_o), ALIGN_EN ? 32'd1 : 32'd0);
    check("mis_addr", imem_addr_o, ALIGN_EN ? 32'h400 : 32'h402);
    if_ready_i = 1;
    repeat (4) step();
    check("mis_sticky", 32'(misalign_o), ALIGN_EN ? 32'd1 : 32'd0);

    // Randomized traffic against the model.
    mem_rand = 1;
    for (int i = 0; i < 600; i++) begin
      stall_i         = ($urandom_range(0, 9) < 3);
      if_ready_i      = ($urandom_range(0, 9) < 6);
      branch_taken_i  = ($urandom_range(0, 9) == 0);
      jump_i          = ($urandom_range(0, 11) == 0);
      branch_base_i   = $urandom & ~32'd3;
      branch_offset_i = ($urandom_range(0, 15) == 0) ? $urandom : ($urandom << 2);
      jump_target_i   = ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & ~32'd3);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
